// File: rtl/fcmp_res_pipe_pkg.sv
// Shared configuration for the FP compare result pipeline: register widths,
// fflags bit positions and the per-stage payload struct.
package fcmp_res_pipe_pkg;

  localparam int FLEN = 64;
  localparam int XLEN = 64;

  // Bit positions within fflags {NV,DZ,OF,UF,NX}
  localparam int NV = 4;
  localparam int DZ = 3;
  localparam int OF = 2;
  localparam int UF = 1;
  localparam int NX = 0;

  typedef struct packed {
    logic            to_int;
    logic            nv;
    logic [FLEN-1:0] fp_res;
    logic [XLEN-1:0] int_res;
    logic [4:0]      rd;
  } cmp_stage_t;

endpackage

// File: rtl/fcmp_stage_reg.sv
// One pipeline register for compare results: a valid bit plus payload,
// with clear (kills valid only) taking priority over load-enable.
module fcmp_stage_reg
  import fcmp_res_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic       en,
  input  logic       clr,
  input  logic       d_valid,
  input  cmp_stage_t d,
  output logic       q_valid,
  output cmp_stage_t q
);

  always_ff @(posedge clk) begin
    if (srst) begin
      q_valid <= 1'b0;
      q       <= '0;
    end else if (clr) begin
      // Payload is left stale on purpose; only the valid bit matters downstream.
      q_valid <= 1'b0;
    end else if (en) begin
      q_valid <= d_valid;
      q       <= d;
    end
  end

endmodule

// File: rtl/fcmp_res_pipe.sv
// Carries FP compare results from Execute through Memory to Writeback,
// steers them to the FP or integer register file and accrues the NV flag.
module fcmp_res_pipe
  import fcmp_res_pipe_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            StallM,
  input  logic            FlushM,
  input  logic            StallW,
  input  logic            FlushW,
  input  logic            CmpValidE,
  input  logic            CmpToIntE,
  input  logic            CmpNVE,
  input  logic [FLEN-1:0] CmpFpResE,
  input  logic [XLEN-1:0] CmpIntResE,
  input  logic [4:0]      RdE,
  input  logic            FFlagsWriteW,
  input  logic [4:0]      FFlagsWdataW,
  output logic            FwdValidM,
  output logic [4:0]      RdM,
  output logic [FLEN-1:0] ResM,
  output logic            FRegWriteW,
  output logic            IntRegWriteW,
  output logic [4:0]      RdW,
  output logic [FLEN-1:0] FResW,
  output logic [XLEN-1:0] IntResW,
  output logic [4:0]      FFlags
);

  cmp_stage_t e_stage;
  cmp_stage_t m_stage;
  cmp_stage_t w_stage;
  logic       valid_m;
  logic       valid_w;
  logic       retire_w;
  logic [FLEN-1:0] int_res_m_ext;

  always_comb begin
    e_stage         = '0;
    e_stage.to_int  = CmpToIntE;
    e_stage.nv      = CmpNVE;
    e_stage.fp_res  = CmpFpResE;
    e_stage.int_res = CmpIntResE;
    e_stage.rd      = RdE;
  end

  fcmp_stage_reg u_stage_m (
    .clk     (clk),
    .srst    (reset),
    .en      (~StallM),
    .clr     (FlushM),
    .d_valid (CmpValidE),
    .d       (e_stage),
    .q_valid (valid_m),
    .q       (m_stage)
  );

  // A stalled M must not be duplicated into W, so W takes a bubble instead.
  fcmp_stage_reg u_stage_w (
    .clk     (clk),
    .srst    (reset),
    .en      (~StallW),
    .clr     (FlushW),
    .d_valid (valid_m & ~StallM),
    .d       (m_stage),
    .q_valid (valid_w),
    .q       (w_stage)
  );

  generate
    if (XLEN < FLEN) begin : g_int_zext
      assign int_res_m_ext = {{(FLEN-XLEN){1'b0}}, m_stage.int_res};
    end else begin : g_int_trunc
      assign int_res_m_ext = m_stage.int_res[FLEN-1:0];
    end
  endgenerate

  assign FwdValidM    = valid_m;
  assign RdM          = m_stage.rd;
  assign ResM         = m_stage.to_int ? int_res_m_ext : m_stage.fp_res;

  assign FRegWriteW   = valid_w & ~w_stage.to_int;
  assign IntRegWriteW = valid_w &  w_stage.to_int;
  assign RdW          = w_stage.rd;
  assign FResW        = w_stage.fp_res;
  assign IntResW      = w_stage.int_res;

  assign retire_w     = valid_w & ~StallW & ~FlushW;

  // A same-cycle CSR write is younger and serialising, so it overrides the retiring NV.
  always_ff @(posedge clk) begin
    if (reset) begin
      FFlags <= 5'b0;
    end else if (FFlagsWriteW) begin
      FFlags <= FFlagsWdataW;
    end else if (retire_w & w_stage.nv) begin
      FFlags[NV] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fcmp_res_pipe.sv
// Directed bench for fcmp_res_pipe with a writeback scoreboard.
module tb_fcmp_res_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallM, FlushM, StallW, FlushW;
  logic        CmpValidE, CmpToIntE, CmpNVE;
  logic [63:0] CmpFpResE, CmpIntResE;
  logic [4:0]  RdE;
  logic        FFlagsWriteW;
  logic [4:0]  FFlagsWdataW;
  logic        FwdValidM;
  logic [4:0]  RdM;
  logic [63:0] ResM;
  logic        FRegWriteW, IntRegWriteW;
  logic [4:0]  RdW;
  logic [63:0] FResW, IntResW;
  logic [4:0]  FFlags;

  typedef struct {
    logic        to_int;
    logic [63:0] data;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total    = 0;
  int   writes   = 0;
  int   w0;

  fcmp_res_pipe dut (
    .clk          (clk),
    .reset        (reset),
    .StallM       (StallM),
    .FlushM       (FlushM),
    .StallW       (StallW),
    .FlushW       (FlushW),
    .CmpValidE    (CmpValidE),
    .CmpToIntE    (CmpToIntE),
    .CmpNVE       (CmpNVE),
    .CmpFpResE    (CmpFpResE),
    .CmpIntResE   (CmpIntResE),
    .RdE          (RdE),
    .FFlagsWriteW (FFlagsWriteW),
    .FFlagsWdataW (FFlagsWdataW),
    .FwdValidM    (FwdValidM),
    .RdM          (RdM),
    .ResM         (ResM),
    .FRegWriteW   (FRegWriteW),
    .IntRegWriteW (IntRegWriteW),
    .RdW          (RdW),
    .FResW        (FResW),
    .IntResW      (IntResW),
    .FFlags       (FFlags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Regfile writes that really take effect this edge are matched against the scoreboard.
  task automatic monitor();
    exp_t e;
    assert (!(StallW && !StallM)) else $error("illegal stimulus: StallW without StallM");
    if ((FRegWriteW || IntRegWriteW) && !StallW && !FlushW) begin
      writes++;
      $display("t=%0t wb rd=%0d int=%0b fp=%0b fres=%h ires=%h", $time, RdW,
               IntRegWriteW, FRegWriteW, FResW, IntResW);
      if (sb.size() == 0) begin
        chk("unexpected_write", {63'b0, FRegWriteW | IntRegWriteW}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_int_sel", {63'b0, IntRegWriteW}, {63'b0, e.to_int});
        chk("wb_fp_sel", {63'b0, FRegWriteW}, {63'b0, ~e.to_int});
        chk("wb_rd", {59'b0, RdW}, {59'b0, e.rd});
        chk("wb_data", e.to_int ? IntResW : FResW, e.data);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic ti, input logic nv, input logic [63:0] fp,
                    input logic [63:0] ir, input logic [4:0] rd, input bit expect_wb);
    exp_t e;
    CmpValidE  = 1'b1;
    CmpToIntE  = ti;
    CmpNVE     = nv;
    CmpFpResE  = fp;
    CmpIntResE = ir;
    RdE        = rd;
    if (expect_wb) begin
      e.to_int = ti;
      e.data   = ti ? ir : fp;
      e.rd     = rd;
      sb.push_back(e);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fwdvalid"}, {63'b0, FwdValidM}, 64'd0);
    chk({tag, "_rdm"}, {59'b0, RdM}, 64'd0);
    chk({tag, "_resm"}, ResM, 64'd0);
    chk({tag, "_fregwr"}, {63'b0, FRegWriteW}, 64'd0);
    chk({tag, "_intregwr"}, {63'b0, IntRegWriteW}, 64'd0);
    chk({tag, "_rdw"}, {59'b0, RdW}, 64'd0);
    chk({tag, "_fresw"}, FResW, 64'd0);
    chk({tag, "_intresw"}, IntResW, 64'd0);
    chk({tag, "_fflags"}, {59'b0, FFlags}, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    StallM = 1'b0; FlushM = 1'b0; StallW = 1'b0; FlushW = 1'b0;
    CmpValidE = 1'b0; CmpToIntE = 1'b0; CmpNVE = 1'b0;
    CmpFpResE = '0; CmpIntResE = '0; RdE = '0;
    FFlagsWriteW = 1'b0; FFlagsWdataW = '0;

    cycle();
    cycle();
    chk_all_zero("reset");
    reset = 1'b0;

    // feq 1.0 == 1.0 -> integer 1, two cycles later
    op(1'b1, 1'b0, 64'h3FF0_0000_0000_0000, 64'd1, 5'd5, 1'b1);
    cycle();
    CmpValidE = 1'b0;
    chk("feq_fwd_valid", {63'b0, FwdValidM}, 64'd1);
    chk("feq_rdm", {59'b0, RdM}, 64'd5);
    chk("feq_resm", ResM, 64'd1);
    chk("feq_not_yet_w", {63'b0, IntRegWriteW}, 64'd0);
    cycle();
    chk("feq_w_latency", {63'b0, IntRegWriteW}, 64'd1);
    cycle();
    chk("feq_sb_drained", sb.size(), 64'd0);
    chk("feq_fflags", {59'b0, FFlags}, 64'd0);

    // fmin with NV, canonical NaN to the FP file
    op(1'b0, 1'b1, 64'h7FF8_0000_0000_0000, 64'h0, 5'd7, 1'b1);
    cycle();
    CmpValidE = 1'b0;
    chk("fmin_resm", ResM, 64'h7FF8_0000_0000_0000);
    cycle();
    chk("fmin_fregwr", {63'b0, FRegWriteW}, 64'd1);
    cycle();
    chk("fmin_fflags_nv", {59'b0, FFlags}, 64'h10);

    FFlagsWriteW = 1'b1; FFlagsWdataW = 5'b0;
    cycle();
    FFlagsWriteW = 1'b0;
    chk("csr_clear", {59'b0, FFlags}, 64'd0);

    // flt held in M for two cycles
    w0 = writes;
    op(1'b1, 1'b0, {$urandom, $urandom}, 64'd1, 5'd9, 1'b1);
    cycle();
    CmpValidE = 1'b0;
    StallM = 1'b1;
    cycle();
    chk("stall1_fwd", {63'b0, FwdValidM}, 64'd1);
    chk("stall1_bubble", {63'b0, IntRegWriteW}, 64'd0);
    cycle();
    chk("stall2_fwd", {63'b0, FwdValidM}, 64'd1);
    chk("stall2_bubble", {63'b0, IntRegWriteW}, 64'd0);
    StallM = 1'b0;
    cycle();
    chk("stall_release_w", {63'b0, IntRegWriteW}, 64'd1);
    chk("stall_release_m_empty", {63'b0, FwdValidM}, 64'd0);
    cycle();
    chk("stall_one_write", writes - w0, 64'd1);

    // flt with NV killed in W
    w0 = writes;
    op(1'b1, 1'b1, 64'h0, 64'd1, 5'd3, 1'b0);
    cycle();
    CmpValidE = 1'b0;
    cycle();
    FlushW = 1'b1;
    cycle();
    FlushW = 1'b0;
    chk("flushw_no_write", {63'b0, IntRegWriteW}, 64'd0);
    chk("flushw_fflags", {59'b0, FFlags}, 64'd0);
    cycle();
    chk("flushw_write_count", writes - w0, 64'd0);

    // NV retire collides with CSR write: CSR data wins
    op(1'b1, 1'b1, 64'h0, 64'd0, 5'd4, 1'b1);
    cycle();
    CmpValidE = 1'b0;
    cycle();
    FFlagsWriteW = 1'b1; FFlagsWdataW = 5'b00001;
    cycle();
    FFlagsWriteW = 1'b0;
    chk("collide_fflags", {59'b0, FFlags}, 64'h01);
    cycle();
    chk("collide_fflags_hold", {59'b0, FFlags}, 64'h01);

    // Four back-to-back ops, reset while op2 sits in W and op3 in M
    w0 = writes;
    for (int i = 0; i < 4; i++) begin
      op((i % 2) == 0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom},
         5'(10 + i), i < 3);
      cycle();
    end
    CmpValidE = 1'b0;
    reset = 1'b1;
    cycle();
    chk_all_zero("midreset");
    reset = 1'b0;
    cycle();
    cycle();
    cycle();
    chk("midreset_writes", writes - w0, 64'd3);
    chk("final_sb_empty", sb.size(), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
